// File: rtl/e203_axi_sram_slv.sv
// AXI4 slave that terminates one read or write burst at a time into a single-port
// synchronous SRAM (1-cycle read latency), with round-robin read/write arbitration.
module e203_axi_sram_slv #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned RAM_AW    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              axi_arvalid,
   output logic              axi_arready,
   input  logic [31:0]       axi_araddr,
   input  logic [3:0]        axi_arid,
   input  logic [7:0]        axi_arlen,
   input  logic [2:0]        axi_arsize,
   input  logic [1:0]        axi_arburst,
   input  logic              axi_arcache,
   input  logic              axi_arprot,
   input  logic              axi_arlock,
   input  logic              axi_awvalid,
   output logic              axi_awready,
   input  logic [31:0]       axi_awaddr,
   input  logic [3:0]        axi_awid,
   input  logic [7:0]        axi_awlen,
   input  logic [2:0]        axi_awsize,
   input  logic [1:0]        axi_awburst,
   input  logic              axi_awcache,
   input  logic              axi_awprot,
   input  logic              axi_awlock,
   input  logic              axi_wvalid,
   output logic              axi_wready,
   input  logic [63:0]       axi_wdata,
   input  logic [7:0]        axi_wstrb,
   input  logic              axi_wlast,
   output logic              axi_rvalid,
   input  logic              axi_rready,
   output logic [63:0]       axi_rdata,
   output logic [1:0]        axi_rresp,
   output logic              axi_rlast,
   output logic [3:0]        axi_rid,
   output logic              axi_bvalid,
   input  logic              axi_bready,
   output logic [1:0]        axi_bresp,
   output logic [3:0]        axi_bid,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_wem,
   output logic [63:0]       ram_din,
   input  logic [63:0]       ram_dout
);

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_e;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [31:0] WIN_SIZE    = 32'd1 << (RAM_AW + 3);

   function automatic logic in_win(input logic [31:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WIN_SIZE);
   endfunction

   state_e      state_q, state_d;
   logic        pref_rd_q, pref_rd_d;
   logic [3:0]  id_q, id_d;
   logic [7:0]  len_q, len_d;
   logic [2:0]  size_q, size_d;
   logic [1:0]  burst_q, burst_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  resp_q, resp_d;
   logic [8:0]  icnt_q, icnt_d, rbeat_q, rbeat_d, wbeat_q, wbeat_d;
   logic        inflight_q, inflight_d;
   logic        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [63:0] fifo_q [2];

   logic [31:0] req_addr, req_last, next_addr, off;
   logic [7:0]  req_len;
   logic [2:0]  req_size;
   logic [1:0]  req_burst, req_resp;
   logic [3:0]  req_id;
   logic [2:0]  occ;
   logic        pop, push, iss, w_hs, wr_en;

   // Request fields are taken from whichever channel wins arbitration this cycle
   assign axi_arready = (state_q == IDLE) & axi_arvalid & (~axi_awvalid | pref_rd_q);
   assign axi_awready = (state_q == IDLE) & axi_awvalid & (~axi_arvalid | ~pref_rd_q);
   assign req_addr    = axi_arready ? axi_araddr  : axi_awaddr;
   assign req_len     = axi_arready ? axi_arlen   : axi_awlen;
   assign req_size    = axi_arready ? axi_arsize  : axi_awsize;
   assign req_burst   = axi_arready ? axi_arburst : axi_awburst;
   assign req_id      = axi_arready ? axi_arid    : axi_awid;
   assign req_last    = (req_burst == 2'b00) ? req_addr : req_addr + ({24'd0, req_len} << req_size);
   // A wrapped 32-bit end address means the burst ran past the window
   assign req_resp    = (req_burst[1] || (req_size > 3'd3)) ? RESP_SLVERR :
                        (!in_win(req_addr) || !in_win(req_last) || (req_last < req_addr)) ? RESP_DECERR :
                        RESP_OKAY;

   assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);
   assign off       = addr_q - BASE_ADDR;

   assign axi_rvalid = (cnt_q != 2'd0);
   assign pop        = axi_rvalid & axi_rready;
   assign push       = inflight_q;
   assign axi_rdata  = fifo_q[rptr_q];
   assign axi_rlast  = axi_rvalid & (rbeat_q == {1'b0, len_q});
   assign axi_rid    = id_q;
   assign axi_rresp  = resp_q;
   // Counting this cycle's pop keeps back-to-back beats flowing with only two slots
   assign occ        = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, inflight_q};
   assign iss        = (state_q == RD) & (icnt_q <= {1'b0, len_q}) & (occ < 3'd2);

   assign axi_wready = (state_q == WR);
   assign w_hs       = axi_wvalid & axi_wready;
   assign wr_en      = w_hs & (wbeat_q <= {1'b0, len_q}) & (resp_q == RESP_OKAY);
   assign axi_bvalid = (state_q == WRESP);
   assign axi_bid    = id_q;
   assign axi_bresp  = resp_q;

   assign ram_cs   = (iss & (resp_q == RESP_OKAY)) | wr_en;
   assign ram_we   = wr_en;
   assign ram_addr = off[RAM_AW+2:3];
   assign ram_wem  = wr_en ? axi_wstrb : 8'h00;
   assign ram_din  = axi_wdata;

   logic unused_ok;
   assign unused_ok = ^{axi_arcache, axi_arprot, axi_arlock, axi_awcache, axi_awprot,
                        axi_awlock, off[31:RAM_AW+3], off[2:0]};

   always_comb begin
      state_d    = state_q;
      pref_rd_d  = pref_rd_q;
      id_d       = id_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      addr_d     = addr_q;
      resp_d     = resp_q;
      icnt_d     = icnt_q;
      rbeat_d    = rbeat_q;
      wbeat_d    = wbeat_q;
      inflight_d = iss;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
      wptr_d     = wptr_q ^ push;
      rptr_d     = rptr_q ^ pop;
      case (state_q)
         IDLE: begin
            if (axi_arready || axi_awready) begin
               state_d   = axi_arready ? RD : WR;
               pref_rd_d = ~axi_arready;
               id_d      = req_id;
               len_d     = req_len;
               size_d    = req_size;
               burst_d   = req_burst;
               addr_d    = req_addr;
               resp_d    = req_resp;
               icnt_d    = '0;
               rbeat_d   = '0;
               wbeat_d   = '0;
            end
         end
         RD: begin
            if (iss) begin
               addr_d = next_addr;
               icnt_d = icnt_q + 9'd1;
            end
            if (pop) rbeat_d = rbeat_q + 9'd1;
            if (pop && axi_rlast) state_d = IDLE;
         end
         WR: begin
            if (w_hs) begin
               if (wbeat_q > {1'b0, len_q}) resp_d = RESP_SLVERR;
               else if (axi_wlast && (wbeat_q < {1'b0, len_q})) resp_d = RESP_SLVERR;
               if (wbeat_q <= {1'b0, len_q}) addr_d = next_addr;
               if (wbeat_q != 9'h1FF) wbeat_d = wbeat_q + 9'd1;
               if (axi_wlast) state_d = WRESP;
            end
         end
         WRESP: begin
            if (axi_bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pref_rd_q  <= 1'b1;
         id_q       <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         addr_q     <= BASE_ADDR;
         resp_q     <= RESP_OKAY;
         icnt_q     <= '0;
         rbeat_q    <= '0;
         wbeat_q    <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= '0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pref_rd_q  <= pref_rd_d;
         id_q       <= id_d;
         len_q      <= len_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         addr_q     <= addr_d;
         resp_q     <= resp_d;
         icnt_q     <= icnt_d;
         rbeat_q    <= rbeat_d;
         wbeat_q    <= wbeat_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   // Errored read bursts push zero beats in place of RAM data
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) fifo_q[gi] <= '0;
         else if (push && (wptr_q == 1'(gi))) fifo_q[gi] <= (resp_q == RESP_OKAY) ? ram_dout : 64'd0;
      end
   end

endmodule

// File: tb/tb_e203_axi_sram_slv.sv
// Directed bench for e203_axi_sram_slv: a vector table of AXI bursts against a RAM
// model, plus hand sequences for arbitration order and reset during a burst.
module tb_e203_axi_sram_slv;
   localparam int RAM_AW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic axi_arvalid = 0, axi_arready, axi_arcache = 0, axi_arprot = 0, axi_arlock = 0;
   logic [31:0] axi_araddr = 0;
   logic [3:0] axi_arid = 0;
   logic [7:0] axi_arlen = 0;
   logic [2:0] axi_arsize = 0;
   logic [1:0] axi_arburst = 0;
   logic axi_awvalid = 0, axi_awready, axi_awcache = 0, axi_awprot = 0, axi_awlock = 0;
   logic [31:0] axi_awaddr = 0;
   logic [3:0] axi_awid = 0;
   logic [7:0] axi_awlen = 0;
   logic [2:0] axi_awsize = 0;
   logic [1:0] axi_awburst = 0;
   logic axi_wvalid = 0, axi_wready, axi_wlast = 0;
   logic [63:0] axi_wdata = 0;
   logic [7:0] axi_wstrb = 0;
   logic axi_rvalid, axi_rready = 0, axi_rlast;
   logic [63:0] axi_rdata;
   logic [1:0] axi_rresp;
   logic [3:0] axi_rid;
   logic axi_bvalid, axi_bready = 0;
   logic [1:0] axi_bresp;
   logic [3:0] axi_bid;
   logic ram_cs, ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [7:0] ram_wem;
   logic [63:0] ram_din, ram_dout;

   e203_axi_sram_slv #(.BASE_ADDR(32'h8000_0000), .RAM_AW(RAM_AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
      .axi_arlock(axi_arlock),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
      .axi_awburst(axi_awburst), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
      .axi_awlock(axi_awlock),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Synchronous RAM model: registered read, byte-masked write
   bit [63:0] mem [int];
   always @(posedge clk) begin : ram_model
      logic [63:0] w;
      int k;
      k = int'(ram_addr);
      w = mem.exists(k) ? mem[k] : 64'd0;
      if (ram_cs && !ram_we) ram_dout <= w;
      if (ram_cs && ram_we) begin
         for (int b = 0; b < 8; b++) if (ram_wem[b]) w[8*b +: 8] = ram_din[8*b +: 8];
         mem[k] = w;
      end
   end

   int n_rd = 0, n_wr = 0, n_wem_bad = 0, n_rst_acc = 0;
   logic [7:0] cur_strb = 8'hFF;
   always @(negedge clk) begin
      if (ram_cs && !ram_we) n_rd++;
      if (ram_cs && ram_we) begin
         n_wr++;
         if (ram_wem != cur_strb) n_wem_bad++;
      end
      if (!rst_n && (ram_cs || ram_we)) n_rst_acc++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic to_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic aw_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bt, input logic [3:0] id);
      int n = 0;
      axi_awaddr = a; axi_awlen = l; axi_awsize = s; axi_awburst = bt; axi_awid = id;
      axi_awvalid = 1;
      mid();
      while (!axi_awready && n < 50) begin mid(); n++; end
      if (!axi_awready) to_fail("aw_wait");
      @(posedge clk); #1;
      axi_awvalid = 0;
   endtask

   task automatic ar_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] bt, input logic [3:0] id);
      int n = 0;
      axi_araddr = a; axi_arlen = l; axi_arsize = s; axi_arburst = bt; axi_arid = id;
      axi_arvalid = 1;
      mid();
      while (!axi_arready && n < 50) begin mid(); n++; end
      if (!axi_arready) to_fail("ar_wait");
      @(posedge clk); #1;
      axi_arvalid = 0;
   endtask

   task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last);
      int n = 0;
      axi_wvalid = 1; axi_wdata = d; axi_wstrb = s; axi_wlast = last;
      mid();
      while (!axi_wready && n < 50) begin mid(); n++; end
      if (!axi_wready) to_fail("w_wait");
      @(posedge clk); #1;
      axi_wvalid = 0; axi_wlast = 0;
   endtask

   task automatic b_resp(input logic [1:0] resp, input logic [3:0] id);
      int n = 0;
      axi_bready = 1;
      mid();
      while (!axi_bvalid && n < 50) begin mid(); n++; end
      if (!axi_bvalid) to_fail("b_wait");
      else begin
         chk("bresp", 64'(axi_bresp), 64'(resp));
         chk("bid", 64'(axi_bid), 64'(id));
      end
      @(posedge clk); #1;
      axi_bready = 0;
   endtask

   task automatic r_beat(input logic [63:0] d, input logic [3:0] id, input logic [1:0] resp,
                         input logic last);
      int n = 0;
      axi_rready = 1;
      mid();
      while (!axi_rvalid && n < 50) begin mid(); n++; end
      if (!axi_rvalid) to_fail("r_wait");
      else begin
         chk("r1_rdata", axi_rdata, d);
         chk("r1_rid", 64'(axi_rid), 64'(id));
         chk("r1_rresp", 64'(axi_rresp), 64'(resp));
         chk("r1_rlast", 64'(axi_rlast), 64'(last));
      end
      @(posedge clk); #1;
      axi_rready = 0;
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic [63:0] d0;     // beat i carries d0*(i+1) (INCR) or d0 (FIXED)
      logic [7:0]  strb;
      int          nbeats; // write beats sent, wlast on the final one
      bit          stall;  // read: rready cycles 1,0,0,1
      logic [1:0]  resp;
      int          nram;   // RAM accesses expected for the burst
   } vec_t;

   vec_t vt [15];

   task automatic do_write(input vec_t v);
      int wr0, rd0, bad0;
      wr0 = n_wr; rd0 = n_rd; bad0 = n_wem_bad;
      cur_strb = v.strb;
      aw_req(v.addr, v.len, v.size, v.burst, v.id);
      for (int i = 0; i < v.nbeats; i++) w_beat(v.d0 * 64'(i + 1), v.strb, i == v.nbeats - 1);
      b_resp(v.resp, v.id);
      chk("ram_writes", 64'(n_wr - wr0), 64'(v.nram));
      chk("ram_reads_in_write", 64'(n_rd - rd0), 64'd0);
      chk("ram_wem", 64'(n_wem_bad - bad0), 64'd0);
   endtask

   task automatic do_read(input vec_t v);
      int rd0, beat, cyc;
      bit prev_stall;
      logic [63:0] prev_data, exp;
      rd0 = n_rd; beat = 0; cyc = 0; prev_stall = 0; prev_data = 0;
      ar_req(v.addr, v.len, v.size, v.burst, v.id);
      while (beat <= int'(v.len) && cyc < 300) begin
         axi_rready = v.stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         mid();
         if (prev_stall) begin
            chk("rvalid_hold", 64'(axi_rvalid), 64'd1);
            chk("rdata_hold", axi_rdata, prev_data);
         end
         if (axi_rvalid && axi_rready) begin
            exp = (v.burst == 2'b00) ? v.d0 : v.d0 * 64'(beat + 1);
            chk("rdata", axi_rdata, exp);
            chk("rresp", 64'(axi_rresp), 64'(v.resp));
            chk("rid", 64'(axi_rid), 64'(v.id));
            chk("rlast", 64'(axi_rlast), 64'(beat == int'(v.len)));
            beat++;
         end
         prev_stall = axi_rvalid && !axi_rready;
         prev_data = axi_rdata;
         if (v.stall) chk("rd_ahead", 64'((n_rd - rd0 - beat) <= 2), 64'd1);
         @(posedge clk); #1;
         cyc++;
      end
      axi_rready = 0;
      if (beat <= int'(v.len)) to_fail("read_beats");
      chk("ram_reads", 64'(n_rd - rd0), 64'(v.nram));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      //        wr    addr           len    size  burst  id     d0                      strb   nb st resp   nram
      vt[0]  = '{1'b1, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd5, 64'h11,                 8'hFF, 4, 0, 2'b00, 4};
      vt[1]  = '{1'b0, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd5, 64'h11,                 8'hFF, 0, 0, 2'b00, 4};
      vt[2]  = '{1'b0, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd9, 64'h11,                 8'hFF, 0, 1, 2'b00, 4};
      vt[3]  = '{1'b0, 32'h8000_0010, 8'd2, 3'd3, 2'b00, 4'd3, 64'h33,                 8'hFF, 0, 0, 2'b00, 3};
      vt[4]  = '{1'b0, 32'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, 4'd2, 64'h0,                  8'hFF, 0, 0, 2'b11, 0};
      vt[5]  = '{1'b1, 32'h8000_0000, 8'd1, 3'd3, 2'b10, 4'd6, 64'hDEAD,               8'hFF, 2, 0, 2'b10, 0};
      vt[6]  = '{1'b1, 32'h8000_0100, 8'd1, 3'd3, 2'b01, 4'd4, 64'h1111_1111_1111_1111, 8'h0F, 2, 0, 2'b00, 2};
      vt[7]  = '{1'b0, 32'h8000_0100, 8'd1, 3'd3, 2'b01, 4'd4, 64'h0000_0000_1111_1111, 8'hFF, 0, 0, 2'b00, 2};
      vt[8]  = '{1'b0, 32'h8000_0000, 8'd0, 3'd4, 2'b01, 4'd1, 64'h0,                  8'hFF, 0, 0, 2'b10, 0};
      vt[9]  = '{1'b1, 32'h8007_FFF8, 8'd1, 3'd3, 2'b01, 4'd2, 64'hBEEF,               8'hFF, 2, 0, 2'b11, 0};
      vt[10] = '{1'b0, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd12, 64'h11,                8'hFF, 0, 1, 2'b00, 4};
      vt[11] = '{1'b1, 32'h8000_0200, 8'd1, 3'd3, 2'b01, 4'd10, 64'h55,                8'hFF, 1, 0, 2'b10, 1};
      vt[12] = '{1'b1, 32'h8000_0208, 8'd0, 3'd3, 2'b01, 4'd11, 64'hAA,                8'hFF, 2, 0, 2'b10, 1};
      vt[13] = '{1'b0, 32'h8000_0200, 8'd1, 3'd3, 2'b01, 4'd13, 64'h55,                8'hFF, 0, 0, 2'b00, 2};
      vt[14] = '{1'b0, 32'h8000_0018, 8'd0, 3'd3, 2'b01, 4'd15, 64'h44,                8'hFF, 0, 0, 2'b00, 1};

      mid();
      chk("reset_ctrl", 64'({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_rlast,
                             axi_bvalid, ram_cs, ram_we}), 64'd0);
      chk("reset_ids", 64'({axi_rresp, axi_bresp, axi_rid, axi_bid}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         if (vt[i].wr) do_write(vt[i]);
         else do_read(vt[i]);
         $display("txn %0d %s addr=%h len=%0d burst=%0d id=%0d checks=%0d errors=%0d",
                  i, vt[i].wr ? "WR" : "RD", vt[i].addr, vt[i].len, vt[i].burst, vt[i].id,
                  checks, errors);
      end

      // Reset in the middle of a write burst: no further RAM access, handshakes drop
      cur_strb = 8'hFF;
      aw_req(32'h8000_0300, 8'd3, 3'd3, 2'b01, 4'd1);
      axi_wvalid = 1; axi_wdata = 64'h99; axi_wstrb = 8'hFF; axi_wlast = 0;
      mid();
      chk("pre_rst_wready", 64'(axi_wready), 64'd1);
      @(posedge clk); #1;
      acc0 = n_rst_acc;
      rst_n = 0;
      mid();
      chk("rst_abort", 64'({axi_wready, ram_cs, ram_we, axi_bvalid, axi_rvalid}), 64'd0);
      @(posedge clk); #1;
      mid();
      chk("rst_no_ram", 64'(n_rst_acc - acc0), 64'd0);
      @(posedge clk); #1;
      axi_wvalid = 0;
      rst_n = 1;
      $display("txn reset-abort checks=%0d errors=%0d", checks, errors);

      // Simultaneous AR/AW from reset: read first, then write
      axi_araddr = 32'h8000_0000; axi_arlen = 0; axi_arsize = 3; axi_arburst = 1; axi_arid = 7;
      axi_awaddr = 32'h8000_0020; axi_awlen = 0; axi_awsize = 3; axi_awburst = 1; axi_awid = 8;
      axi_arvalid = 1; axi_awvalid = 1;
      mid();
      chk("arb_read_first", 64'({axi_arready, axi_awready}), 64'b10);
      @(posedge clk); #1;
      axi_arvalid = 0;
      r_beat(64'h11, 4'd7, 2'b00, 1'b1);
      axi_arvalid = 1;
      mid();
      chk("arb_write_next", 64'({axi_arready, axi_awready}), 64'b01);
      @(posedge clk); #1;
      axi_awvalid = 0;
      w_beat(64'h66, 8'hFF, 1'b1);
      b_resp(2'b00, 4'd8);
      mid();
      chk("arb_read_pending", 64'({axi_arready, axi_awready}), 64'b10);
      @(posedge clk); #1;
      axi_arvalid = 0;
      r_beat(64'h11, 4'd7, 2'b00, 1'b1);
      $display("txn arbitration checks=%0d errors=%0d", checks, errors);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
